// File: rtl/avr_serial_tx.sv
// 8N1 UART transmitter toward the AVR serial bridge, with a small byte FIFO
// and frame-granular honouring of the AVR's receive-busy flow control.
module avr_serial_tx #(
    parameter int CLK_PER_BIT = 100,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [7:0]                    tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    input  logic                          avr_rx_busy,
    output logic                          avr_rx,
    output logic                          idle,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CW    = PTR_W + 1;
    localparam int CNT_W = $clog2(CLK_PER_BIT);
    localparam logic [CW-1:0]    FULL     = CW'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLK_PER_BIT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t            state, state_nx;
    logic [CNT_W-1:0]  bit_cnt, bit_cnt_nx;
    logic [2:0]        bit_idx, bit_idx_nx;
    logic [7:0]        shift, shift_nx;
    logic              rx_nx;
    logic              pop;
    logic              push;
    logic              bit_done;

    logic [7:0]        mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;

    logic              busy_meta, busy_s;

    assign tx_ready = (fifo_count != FULL);
    assign push     = tx_valid && tx_ready;
    assign idle     = (state == S_IDLE) && (fifo_count == '0);
    assign bit_done = (bit_cnt == BIT_LAST);

    // avr_rx_busy is asynchronous; two flops before the IDLE decision uses it
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_meta <= 1'b0;
            busy_s    <= 1'b0;
        end else begin
            busy_meta <= avr_rx_busy;
            busy_s    <= busy_meta;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= tx_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CW'(1);
                2'b01:   fifo_count <= fifo_count - CW'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            bit_cnt <= '0;
            bit_idx <= '0;
            avr_rx  <= 1'b1;
        end else begin
            state   <= state_nx;
            bit_cnt <= bit_cnt_nx;
            bit_idx <= bit_idx_nx;
            avr_rx  <= rx_nx;
        end
    end

    always_ff @(posedge clk) begin
        shift <= shift_nx;
    end

    // The line level is computed for the state being entered, so avr_rx
    // changes on the same edge as the state register.
    always_comb begin
        state_nx   = state;
        bit_cnt_nx = bit_cnt + CNT_W'(1);
        bit_idx_nx = bit_idx;
        shift_nx   = shift;
        rx_nx      = avr_rx;
        pop        = 1'b0;
        case (state)
            S_IDLE: begin
                bit_cnt_nx = '0;
                rx_nx      = 1'b1;
                if ((fifo_count != '0) && !busy_s) begin
                    pop      = 1'b1;
                    shift_nx = mem[rd_ptr];
                    state_nx = S_START;
                    rx_nx    = 1'b0;
                end
            end
            S_START: begin
                if (bit_done) begin
                    bit_cnt_nx = '0;
                    bit_idx_nx = '0;
                    state_nx   = S_DATA;
                    rx_nx      = shift[0];
                end
            end
            S_DATA: begin
                if (bit_done) begin
                    bit_cnt_nx = '0;
                    if (bit_idx == 3'd7) begin
                        state_nx = S_STOP;
                        rx_nx    = 1'b1;
                    end else begin
                        shift_nx   = {1'b0, shift[7:1]};
                        rx_nx      = shift[1];
                        bit_idx_nx = bit_idx + 3'd1;
                    end
                end
            end
            S_STOP: begin
                if (bit_done) begin
                    bit_cnt_nx = '0;
                    state_nx   = S_IDLE;
                end
            end
            default: begin
                state_nx = S_IDLE;
                rx_nx    = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_avr_serial_tx.sv
// Directed bench for avr_serial_tx: exact line timing, flow control, FIFO
// full/simultaneous push-pop, reset mid-frame and a 20-byte wrap stream.
module tb_avr_serial_tx;

    localparam int CPB   = 100;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       avr_rx_busy;
    logic       avr_rx;
    logic       idle;
    logic [2:0] fifo_count;

    int checks   = 0;
    int failures = 0;

    int cyc = 0;
    logic [7:0] rx_q[$];
    int         start_q[$];
    int         mon_err = 0;
    logic       mon_act = 1'b0;

    logic [7:0] a5 = 8'hA5;
    logic [7:0] sent [20];
    int         wait_cnt;
    int         timeouts;

    avr_serial_tx #(.CLK_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .avr_rx_busy(avr_rx_busy),
        .avr_rx     (avr_rx),
        .idle       (idle),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Serial receiver: mid-bit sampling, records each frame's start cycle
    initial begin
        int ph;
        int idx;
        logic [7:0] b;
        ph = 0;
        b  = 8'h00;
        forever begin
            @(negedge clk);
            if (!mon_act) begin
                if (avr_rx === 1'b0) begin
                    mon_act = 1'b1;
                    ph      = 0;
                    b       = 8'h00;
                    start_q.push_back(cyc);
                end
            end else begin
                ph++;
                if (ph % CPB == CPB / 2) begin
                    idx = ph / CPB;
                    if (idx == 0 && avr_rx !== 1'b0) mon_err++;
                    else if (idx >= 1 && idx <= 8) b[idx-1] = avr_rx;
                    else if (idx == 9 && avr_rx !== 1'b1) mon_err++;
                end
                if (ph == 10 * CPB - 1) begin
                    rx_q.push_back(b);
                    mon_act = 1'b0;
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst         = 1'b1;
        tx_data     = 8'h00;
        tx_valid    = 1'b0;
        avr_rx_busy = 1'b0;
        tick(3);
        check("rst_avr_rx", avr_rx, 1);
        check("rst_tx_ready", tx_ready, 1);
        check("rst_fifo_count", fifo_count, 0);
        check("rst_idle", idle, 1);
        rst = 1'b0;
        tick(2);

        // Single byte 0xA5 with exact bit timing
        tx_data  = 8'hA5;
        tx_valid = 1'b1;
        tick(1);
        check("e0_count", fifo_count, 1);
        check("e0_line", avr_rx, 1);
        check("e0_idle", idle, 0);
        tx_valid = 1'b0;
        tick(1);
        check("e1_start", avr_rx, 0);
        check("e1_count", fifo_count, 0);
        tick(CPB - 1);
        check("start_end", avr_rx, 0);
        tick(1);
        for (int k = 0; k < 8; k++) begin
            check($sformatf("a5_bit%0d", k), avr_rx, a5[k]);
            tick(CPB);
        end
        check("stop_line", avr_rx, 1);
        check("stop_idle", idle, 0);
        tick(CPB - 1);
        check("stop_end_idle", idle, 0);
        tick(1);
        check("idle_after_stop", idle, 1);
        check("a5_rx_count", rx_q.size(), 1);
        check("a5_rx_byte", rx_q[0], 8'hA5);
        rx_q.delete();
        start_q.delete();

        // Busy held: FIFO fills, full push refused even on the pop edge
        avr_rx_busy = 1'b1;
        tick(3);
        tx_valid = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            tx_data = 8'(i);
            tick(1);
        end
        tx_data = 8'h05;
        tick(5);
        check("full_count", fifo_count, 4);
        check("full_ready", tx_ready, 0);
        check("busy_line", avr_rx, 1);
        check("full_idle", idle, 0);
        avr_rx_busy = 1'b0;
        tick(2);
        check("busy_sync_hold", avr_rx, 1);
        tick(1);
        check("busy_release_start", avr_rx, 0);
        check("full_pop_count", fifo_count, 3);
        check("full_pop_ready", tx_ready, 1);
        tick(1);
        check("late_push_count", fifo_count, 4);
        tx_valid = 1'b0;
        tick(5 * (10 * CPB + 1) + 20);
        check("b2b_rx_count", rx_q.size(), 5);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("b2b_byte%0d", i), rx_q[i], 32'(i + 1));
        end
        for (int i = 0; i < 4; i++) begin
            check($sformatf("b2b_period%0d", i), start_q[i+1] - start_q[i], 10 * CPB + 1);
        end
        rx_q.delete();
        start_q.delete();

        // Simultaneous push/pop, then busy raised mid-DATA of the first byte
        tx_data  = 8'h5A;
        tx_valid = 1'b1;
        tick(1);
        check("pp_first_count", fifo_count, 1);
        tx_data = 8'hC3;
        tick(1);
        check("pp_same_edge_count", fifo_count, 1);
        check("pp_start", avr_rx, 0);
        tx_valid = 1'b0;
        tick(350);
        avr_rx_busy = 1'b1;
        tick(700);
        check("hold_line", avr_rx, 1);
        check("hold_count", fifo_count, 1);
        tick(1000);
        check("hold_line_late", avr_rx, 1);
        check("hold_frames", start_q.size(), 1);
        check("hold_first_byte", rx_q[0], 8'h5A);
        avr_rx_busy = 1'b0;
        tick(2);
        check("resume_sync_hold", avr_rx, 1);
        tick(1);
        check("resume_start", avr_rx, 0);
        tick(10 * CPB + 10);
        check("resume_rx_count", rx_q.size(), 2);
        check("resume_second_byte", rx_q[1], 8'hC3);
        rx_q.delete();
        start_q.delete();

        // Reset during data bit 3 with two bytes queued
        tx_valid = 1'b1;
        tx_data  = 8'h11;
        tick(1);
        tx_data = 8'h22;
        tick(1);
        tx_data = 8'h33;
        tick(1);
        tx_valid = 1'b0;
        check("pre_rst_count", fifo_count, 2);
        tick(440);
        rst = 1'b1;
        tick(1);
        check("midrst_line", avr_rx, 1);
        check("midrst_count", fifo_count, 0);
        check("midrst_idle", idle, 1);
        rst = 1'b0;
        tick(2500);
        check("post_rst_line", avr_rx, 1);
        check("post_rst_frames", start_q.size(), 1);
        rx_q.delete();
        start_q.delete();
        tx_data  = 8'h3C;
        tx_valid = 1'b1;
        tick(1);
        tx_valid = 1'b0;
        tick(10 * CPB + 10);
        check("fresh_rx_count", rx_q.size(), 1);
        check("fresh_byte", rx_q[0], 8'h3C);
        rx_q.delete();
        start_q.delete();

        // Twenty bytes through the FIFO with random busy toggles
        timeouts = 0;
        for (int i = 0; i < 20; i++) sent[i] = 8'($urandom);
        for (int i = 0; i < 20; i++) begin
            tx_data  = sent[i];
            tx_valid = 1'b1;
            wait_cnt = 0;
            while (tx_ready !== 1'b1 && wait_cnt < 20000) begin
                tick(1);
                wait_cnt++;
                if ($urandom_range(0, 199) == 0) avr_rx_busy = ~avr_rx_busy;
            end
            if (wait_cnt >= 20000) timeouts++;
            tick(1);
            if ($urandom_range(0, 3) == 0) avr_rx_busy = ~avr_rx_busy;
        end
        tx_valid    = 1'b0;
        avr_rx_busy = 1'b0;
        wait_cnt    = 0;
        while (!(idle === 1'b1 && !mon_act) && wait_cnt < 30000) begin
            tick(1);
            wait_cnt++;
        end
        check("wrap_push_timeouts", timeouts, 0);
        check("wrap_drain_timeout", wait_cnt < 30000, 1);
        check("wrap_rx_count", rx_q.size(), 20);
        for (int i = 0; i < 20; i++) begin
            check($sformatf("wrap_byte%0d", i), rx_q[i], sent[i]);
        end
        check("frame_format_errors", mon_err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
